// File: rtl/bram8_arb_if.sv
// Bus bundle between two byte-wide masters, the arbiter and a single-port BRAM.
// slave is the arbiter's view; master is the view of whatever drives the requests.
interface bram8_arb_if #(
    parameter int adr_width = 8
);
    logic                 m0_req;
    logic                 m0_we;
    logic [adr_width-1:0] m0_adr;
    logic [7:0]           m0_dat_w;
    logic [7:0]           m0_dat_r;
    logic                 m0_ack;

    logic                 m1_req;
    logic                 m1_we;
    logic [adr_width-1:0] m1_adr;
    logic [7:0]           m1_dat_w;
    logic [7:0]           m1_dat_r;
    logic                 m1_ack;

    logic [adr_width-1:0] bram_a;
    logic [7:0]           bram_do;
    logic                 bram_we;
    logic [7:0]           bram_di;

    logic                 busy;

    modport slave (
        input  m0_req, m0_we, m0_adr, m0_dat_w,
        output m0_dat_r, m0_ack,
        input  m1_req, m1_we, m1_adr, m1_dat_w,
        output m1_dat_r, m1_ack,
        output bram_a, bram_do, bram_we,
        input  bram_di,
        output busy
    );

    modport master (
        output m0_req, m0_we, m0_adr, m0_dat_w,
        input  m0_dat_r, m0_ack,
        output m1_req, m1_we, m1_adr, m1_dat_w,
        input  m1_dat_r, m1_ack,
        input  bram_a, bram_do, bram_we,
        output bram_di,
        input  busy
    );
endinterface

// File: rtl/bram8_arb.sv
// Two-master round-robin arbiter in front of one BRAM port; one access every 3 cycles.
//
//   state  | meaning
//   IDLE   | waiting for a request; arbitrates and latches the winner's command
//   ACCESS | address/write data on the BRAM port, write enable pulses here
//   ACK    | BRAM read data valid, winner's ack high, last-served pointer updated
module bram8_arb #(
    parameter int adr_width = 8
) (
    input  logic         sys_clk,
    input  logic         sys_rst,
    bram8_arb_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 gnt_q, gnt_d;   // granted master index
    logic                 last_q, last_d; // last master served
    logic [adr_width-1:0] a_q, a_d;
    logic [7:0]           do_q, do_d;
    logic                 we_q, we_d;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            a_q     <= '0;
            do_q    <= 8'h00;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            a_q     <= a_d;
            do_q    <= do_d;
            we_q    <= we_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        a_d     = a_q;
        do_d    = do_q;
        we_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.m0_req || bus.m1_req) begin
                    // m1 wins when it is alone or when m0 was served last
                    gnt_d   = bus.m1_req && (!bus.m0_req || !last_q);
                    a_d     = gnt_d ? bus.m1_adr   : bus.m0_adr;
                    do_d    = gnt_d ? bus.m1_dat_w : bus.m0_dat_w;
                    we_d    = gnt_d ? bus.m1_we    : bus.m0_we;
                    state_d = ACCESS;
                end
            end
            ACCESS: state_d = ACK;
            ACK: begin
                last_d  = gnt_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.bram_a   = a_q;
    assign bus.bram_do  = do_q;
    assign bus.bram_we  = we_q;
    assign bus.m0_ack   = (state_q == ACK) && !gnt_q;
    assign bus.m1_ack   = (state_q == ACK) && gnt_q;
    assign bus.m0_dat_r = bus.bram_di;
    assign bus.m1_dat_r = bus.bram_di;
    assign bus.busy     = (state_q != IDLE);
endmodule

// File: tb/tb_bram8_arb.sv
// Randomized bench for bram8_arb: per-master request drivers, a BRAM model and a
// timeline-based reference of grants, acks and port values checked every cycle.
module tb_bram8_arb;
    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic ram_init = 1'b1;
    always #5 sys_clk = ~sys_clk;

    bram8_arb_if #(.adr_width(8)) bus();
    bram8_arb #(.adr_width(8)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] init_val(input logic [7:0] a);
        return a ^ 8'hB7;
    endfunction

    // BRAM with registered read data
    logic [7:0] ram [256];
    always @(posedge sys_clk) begin
        if (ram_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_val(8'(i));
        end else if (bus.bram_we) begin
            ram[bus.bram_a] <= bus.bram_do;
        end
        bus.bram_di <= ram[bus.bram_a];
    end

    typedef struct packed {
        logic       we;
        logic [7:0] adr;
        logic [7:0] dat;
        logic       pulse;
    } txn_t;

    txn_t       mq [2][$];
    logic       drv_req [2];
    logic       drv_we  [2];
    logic [7:0] drv_adr [2];
    logic [7:0] drv_dat [2];
    logic       active  [2];
    logic       is_pulse[2];
    int         waitc   [2];
    logic       ack_s   [2];
    logic       rst_s = 1'b1;

    assign bus.m0_req   = drv_req[0];
    assign bus.m0_we    = drv_we[0];
    assign bus.m0_adr   = drv_adr[0];
    assign bus.m0_dat_w = drv_dat[0];
    assign bus.m1_req   = drv_req[1];
    assign bus.m1_we    = drv_we[1];
    assign bus.m1_adr   = drv_adr[1];
    assign bus.m1_dat_w = drv_dat[1];

    // Master drivers: hold req until ack, chain the next queued command immediately
    initial begin
        txn_t t;
        for (int m = 0; m < 2; m++) begin
            drv_req[m] = 1'b0; drv_we[m] = 1'b0; drv_adr[m] = 8'h00; drv_dat[m] = 8'h00;
            active[m] = 1'b0; is_pulse[m] = 1'b0; waitc[m] = 0;
        end
        forever begin
            @(posedge sys_clk);
            #1;
            for (int m = 0; m < 2; m++) begin
                if (rst_s) begin
                    drv_req[m] = 1'b0;
                    active[m]  = 1'b0;
                end else begin
                    if (active[m] && (ack_s[m] || is_pulse[m])) begin
                        active[m]  = 1'b0;
                        drv_req[m] = 1'b0;
                    end else if (active[m]) begin
                        waitc[m]++;
                        if (waitc[m] > 40) begin
                            chk("ack_timeout", 1, 0);
                            active[m]  = 1'b0;
                            drv_req[m] = 1'b0;
                        end
                    end
                    if (!active[m] && mq[m].size() > 0) begin
                        t = mq[m].pop_front();
                        drv_we[m]   = t.we;
                        drv_adr[m]  = t.adr;
                        drv_dat[m]  = t.dat;
                        is_pulse[m] = t.pulse;
                        drv_req[m]  = 1'b1;
                        active[m]   = 1'b1;
                        waitc[m]    = 0;
                    end
                end
            end
        end
    end

    // Reference timeline: a grant taken at cycle g puts the command on the port in
    // cycle g, acks in cycle g+1, and the next grant can be taken no earlier than g+3.
    int         cyc = 0;
    logic       mdl_valid = 1'b0;
    int         g_cyc = -100;
    int         free_cyc = 0;
    int         g_m = 0;
    logic       g_we = 1'b0;
    int         last_m = 1;
    logic [7:0] a_e = 8'h00, d_e = 8'h00, rd_e = 8'h00;
    logic [7:0] wr_mem [int];
    logic       prev_we = 1'b0;
    int         ack_cnt [2] = '{0, 0};
    int         ack_log[$];
    int         ack_cyc_log[$];
    logic [7:0] ack_dat_log[$];
    int         we_cnt = 0;

    always @(negedge sys_clk) begin
        int   n;
        logic e_busy, e_we, e_ack0, e_ack1;
        cyc++;
        if (mdl_valid) begin
            e_busy = (cyc == g_cyc) || (cyc == g_cyc + 1);
            e_we   = (cyc == g_cyc) && g_we;
            e_ack0 = (cyc == g_cyc + 1) && (g_m == 0);
            e_ack1 = (cyc == g_cyc + 1) && (g_m == 1);
            chk("busy", int'(bus.busy), int'(e_busy));
            chk("bram_we", int'(bus.bram_we), int'(e_we));
            chk("m0_ack", int'(bus.m0_ack), int'(e_ack0));
            chk("m1_ack", int'(bus.m1_ack), int'(e_ack1));
            chk("bram_a", int'(bus.bram_a), int'(a_e));
            chk("bram_do", int'(bus.bram_do), int'(d_e));
            if ((e_ack0 || e_ack1) && !g_we)
                chk("dat_r", int'(g_m == 1 ? bus.m1_dat_r : bus.m0_dat_r), int'(rd_e));
            chk("ack_both", int'(bus.m0_ack & bus.m1_ack), 0);
            chk("we_twice", int'(prev_we & bus.bram_we), 0);
        end
        if (bus.m0_ack) begin
            ack_cnt[0]++; ack_log.push_back(0); ack_cyc_log.push_back(cyc); ack_dat_log.push_back(bus.m0_dat_r);
        end
        if (bus.m1_ack) begin
            ack_cnt[1]++; ack_log.push_back(1); ack_cyc_log.push_back(cyc); ack_dat_log.push_back(bus.m1_dat_r);
        end
        if (bus.bram_we) we_cnt++;
        prev_we  = bus.bram_we;
        ack_s[0] = bus.m0_ack;
        ack_s[1] = bus.m1_ack;
        rst_s    = sys_rst;

        n = cyc + 1;
        if (sys_rst) begin
            mdl_valid = 1'b1;
            g_cyc     = -100;
            free_cyc  = n + 1;
            last_m    = 1;
            a_e       = 8'h00;
            d_e       = 8'h00;
        end else if (mdl_valid) begin
            if (n == g_cyc + 2) last_m = g_m;
            if (n >= free_cyc && (drv_req[0] || drv_req[1])) begin
                g_m      = (drv_req[0] && drv_req[1]) ? 1 - last_m : (drv_req[1] ? 1 : 0);
                g_cyc    = n;
                free_cyc = n + 3;
                g_we     = drv_we[g_m];
                a_e      = drv_adr[g_m];
                d_e      = drv_dat[g_m];
                rd_e     = wr_mem.exists(int'(a_e)) ? wr_mem[int'(a_e)] : init_val(a_e);
                if (g_we) wr_mem[int'(a_e)] = d_e;
            end
        end
    end

    task automatic push(input int m, input logic we, input logic [7:0] adr,
                        input logic [7:0] dat, input logic pulse);
        txn_t t;
        t.we = we; t.adr = adr; t.dat = dat; t.pulse = pulse;
        mq[m].push_back(t);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge sys_clk);
            #1;
        end
    endtask

    task automatic wait_acks(input int target, input int budget);
        int c = 0;
        while (ack_log.size() < target && c < budget) begin
            idle(1);
            c++;
        end
        if (ack_log.size() < target) chk("wait_acks", ack_log.size(), target);
    endtask

    task automatic pulse_reset();
        @(posedge sys_clk); #1 sys_rst = 1'b1;
        @(posedge sys_clk); #1 sys_rst = 1'b0;
        idle(1);
    endtask

    initial begin
        int base, w0, c0, c1, k;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk); #1;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_we", int'(bus.bram_we), 0);
        chk("rst_a", int'(bus.bram_a), 0);
        chk("rst_do", int'(bus.bram_do), 0);
        chk("rst_acks", int'({bus.m0_ack, bus.m1_ack}), 0);
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        ram_init = 1'b0;
        idle(2);

        // single read
        base = ack_log.size();
        push(0, 1'b0, 8'h12, 8'h00, 1'b0);
        wait_acks(base + 1, 20);
        chk("rd_who", ack_log[base], 0);
        chk("rd_dat", int'(ack_dat_log[base]), 8'hA5);
        idle(3);

        // write then read back
        base = ack_log.size();
        w0 = we_cnt;
        push(1, 1'b1, 8'h40, 8'h3C, 1'b0);
        push(1, 1'b0, 8'h40, 8'h00, 1'b0);
        wait_acks(base + 2, 30);
        chk("wr_who", ack_log[base], 1);
        chk("wr_we_pulses", we_cnt - w0, 1);
        chk("wr_rd_dat", int'(ack_dat_log[base + 1]), 8'h3C);
        idle(3);

        // contention right after reset
        pulse_reset();
        base = ack_log.size();
        push(0, 1'b0, 8'h05, 8'h00, 1'b0);
        push(1, 1'b0, 8'h06, 8'h00, 1'b0);
        wait_acks(base + 2, 30);
        chk("cont_first", ack_log[base], 0);
        chk("cont_second", ack_log[base + 1], 1);
        chk("cont_gap", ack_cyc_log[base + 1] - ack_cyc_log[base], 3);
        idle(3);

        // saturation
        pulse_reset();
        base = ack_log.size();
        c0 = ack_cnt[0]; c1 = ack_cnt[1];
        for (int i = 0; i < 4; i++) begin
            push(0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom), 1'b0);
            push(1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom), 1'b0);
        end
        wait_acks(base + 8, 60);
        for (int i = 0; i < 8; i++) chk("sat_order", ack_log[base + i], i % 2);
        chk("sat_gap", ack_cyc_log[base + 7] - ack_cyc_log[base], 21);
        chk("sat_cnt0", ack_cnt[0] - c0, 4);
        chk("sat_cnt1", ack_cnt[1] - c1, 4);
        idle(3);

        // reset during the ACCESS of an m0 write, after m0 was served last
        base = ack_log.size();
        push(0, 1'b0, 8'h21, 8'h00, 1'b0);
        wait_acks(base + 1, 20);
        idle(2);
        push(0, 1'b1, 8'h22, 8'h99, 1'b0);
        k = 0;
        do begin
            @(posedge sys_clk); #1;
            k++;
        end while (!bus.bram_we && k < 20);
        chk("abort_seen_we", int'(bus.bram_we), 1);
        sys_rst = 1'b1;
        c0 = ack_cnt[0];
        @(posedge sys_clk); #1 sys_rst = 1'b0;
        @(negedge sys_clk); #1;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_we", int'(bus.bram_we), 0);
        idle(4);
        chk("abort_noack", ack_cnt[0] - c0, 0);
        base = ack_log.size();
        push(0, 1'b0, 8'h30, 8'h00, 1'b0);
        push(1, 1'b0, 8'h31, 8'h00, 1'b0);
        wait_acks(base + 2, 30);
        chk("abort_next_first", ack_log[base], 0);
        idle(3);

        // m1 request withdrawn while m0 is being served
        base = ack_log.size();
        c1 = ack_cnt[1];
        w0 = we_cnt;
        push(0, 1'b0, 8'h44, 8'h00, 1'b0);
        k = 0;
        while (!bus.busy && k < 20) begin
            idle(1);
            k++;
        end
        chk("wd_busy_seen", int'(bus.busy), 1);
        push(1, 1'b1, 8'h45, 8'h77, 1'b1);
        idle(8);
        chk("wd_m1_acks", ack_cnt[1] - c1, 0);
        chk("wd_total", ack_log.size() - base, 1);
        chk("wd_no_we", we_cnt - w0, 0);

        // random traffic with occasional resets
        for (int i = 0; i < 500; i++) begin
            idle(1);
            for (int m = 0; m < 2; m++) begin
                if (mq[m].size() < 3 && $urandom_range(0, 2) == 0)
                    push(m, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 31)), 8'($urandom), 1'b0);
            end
            if ($urandom_range(0, 99) == 0) pulse_reset();
        end
        k = 0;
        while ((mq[0].size() > 0 || mq[1].size() > 0 || active[0] || active[1]) && k < 300) begin
            idle(1);
            k++;
        end
        chk("drain", int'(mq[0].size() + mq[1].size()), 0);
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
